// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings, default timing and frame
// constants, and a counter-width helper used by both transmit and receive.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } tx_state_e;

  localparam int BAUD_DIV_DEFAULT   = 163;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DBIT_DEFAULT       = 8;
  localparam int STOP_BITS_DEFAULT  = 1;

  // A counter for n states still needs one bit when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every BAUD_DIV clocks;
// i_clear restarts the count so tick phase can be aligned to an event.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int              CW       = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Divider counter, wraps at BAUD_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_tick = (r_count == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: accepts one byte per write strobe, shifts it out
// LSB first, and flags frame completion and writes dropped while busy.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int STOP_BITS  = STOP_BITS_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tx_write,
  input  logic [DBIT-1:0] i_tx_bus,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_tx_busy,
  output logic            o_tx_overrun
);

  localparam int            TW        = cnt_width(OVERSAMPLE * STOP_BITS);
  localparam int            BW        = cnt_width(DBIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  tx_state_e       r_state;
  logic [DBIT-1:0] r_shift;
  logic [BW-1:0]   r_bit_idx;
  logic [TW-1:0]   r_tick_cnt;
  logic            r_tx;
  logic            r_done;
  logic            r_busy;
  logic            r_overrun;
  logic            w_tick;
  logic            w_accept;

  // Restarting the divider on accept fixes frame timing relative to the write.
  assign w_accept = i_tx_write && (r_state == ST_IDLE);

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_accept),
    .o_tick  (w_tick)
  );

  // Frame sequencer; the line level is registered one state ahead.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_tick_cnt <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= i_tx_write && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (i_tx_write) begin
            r_shift    <= i_tx_bus;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              r_tx       <= r_shift[0];
              r_state    <= ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {1'b0, r_shift[DBIT-1:1]};
              if (r_bit_idx == BIT_LAST) begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end else begin
                r_tx      <= r_shift[1];
                r_bit_idx <= r_bit_idx + BIT_ONE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            if (r_tick_cnt == STOP_LAST) begin
              r_tick_cnt <= '0;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_tx_done    = r_done;
  assign o_tx_busy    = r_busy;
  assign o_tx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-timing model checked every cycle,
// a line decoder, directed corner cases and a default-timing instance.
module tb_uart_tx_serializer;

  localparam int BD = 2;
  localparam int OS = 4;
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int T  = BD * OS;
  localparam int FT = (1 + DB + SB) * T;

  logic       clk = 1'b0;
  logic       rst, wr, rst2, wr2;
  logic [7:0] bus, bus2;
  logic       tx, done, busy, ovr;
  logic       tx2, done2, busy2, ovr2;

  always #5 clk = ~clk;

  uart_tx_serializer #(.BAUD_DIV(BD), .OVERSAMPLE(OS), .DBIT(DB), .STOP_BITS(SB)) dut (
    .i_clk(clk), .i_reset(rst), .i_tx_write(wr), .i_tx_bus(bus),
    .o_tx(tx), .o_tx_done(done), .o_tx_busy(busy), .o_tx_overrun(ovr));

  uart_tx_serializer dut_def (
    .i_clk(clk), .i_reset(rst2), .i_tx_write(wr2), .i_tx_bus(bus2),
    .o_tx(tx2), .o_tx_done(done2), .o_tx_busy(busy2), .o_tx_overrun(ovr2));

  typedef struct {
    int   cyc;
    logic tx;
    logic busy;
    logic done;
  } vec_t;

  int         cyc, t0, n_checks, n_errors, done_cnt;
  logic       model_on;
  int         m_fs;
  logic [7:0] m_byte;
  logic       m_ovr;
  logic       mon_act;
  int         mon_st;
  logic [7:0] mon_sh;
  logic [7:0] mon_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc - t0, act, exp);
    end
  endtask

  // Reference: a frame accepted in cycle w occupies cycles w+1 .. w+FT, done at w+1+FT.
  task automatic model_update();
    if (rst) begin
      m_fs  = -1;
      m_ovr = 1'b0;
    end else if (wr) begin
      if (m_fs < 0 || cyc - m_fs >= FT) begin
        m_fs   = cyc + 1;
        m_byte = bus;
        m_ovr  = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ovr = 1'b0;
    end
  endtask

  task automatic model_check();
    int   o;
    logic e_tx, e_busy, e_done;
    o      = cyc - m_fs;
    e_tx   = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (m_fs >= 0 && o >= 0 && o < FT) begin
      e_busy = 1'b1;
      if (o < T) e_tx = 1'b0;
      else if (o < (1 + DB) * T) e_tx = m_byte[o / T - 1];
    end else if (m_fs >= 0 && o == FT) begin
      e_done = 1'b1;
    end
    chk("model_tx", {31'd0, tx}, {31'd0, e_tx});
    chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("model_done", {31'd0, done}, {31'd0, e_done});
    chk("model_overrun", {31'd0, ovr}, {31'd0, m_ovr});
  endtask

  // Line decoder: samples each bit at its centre after a falling edge.
  task automatic monitor(input logic rst_was);
    int o;
    if (rst_was) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx == 1'b0) begin
        mon_act = 1'b1;
        mon_st  = cyc;
      end
    end else begin
      o = cyc - mon_st;
      if (o >= T + T / 2 && o < (1 + DB) * T && (o - T / 2) % T == 0)
        mon_sh[(o - T / 2) / T - 1] = tx;
      if (o == (1 + DB) * T + T / 2) begin
        if (tx) mon_q.push_back(mon_sh);
        mon_act = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic rst_was;
    rst_was = rst;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    monitor(rst_was);
    if (model_on) model_check();
  endtask

  task automatic wait_to(input int n);
    while (cyc - t0 < n) step();
  endtask

  task automatic start_test();
    repeat (3) step();
    t0 = cyc;
    mon_q.delete();
  endtask

  task automatic pulse_write(input logic [7:0] d);
    wr  = 1'b1;
    bus = d;
    step();
    wr  = 1'b0;
  endtask

  vec_t tbl [17];
  int   cp_cyc [6];
  logic [2:0] cp_exp [6];
  int   dc0;

  initial begin
    tbl = '{'{1, 1'b0, 1'b1, 1'b0},  '{8, 1'b0, 1'b1, 1'b0},  '{9, 1'b1, 1'b1, 1'b0},
            '{16, 1'b1, 1'b1, 1'b0}, '{17, 1'b0, 1'b1, 1'b0}, '{25, 1'b1, 1'b1, 1'b0},
            '{33, 1'b0, 1'b1, 1'b0}, '{41, 1'b0, 1'b1, 1'b0}, '{48, 1'b0, 1'b1, 1'b0},
            '{49, 1'b1, 1'b1, 1'b0}, '{57, 1'b0, 1'b1, 1'b0}, '{65, 1'b1, 1'b1, 1'b0},
            '{72, 1'b1, 1'b1, 1'b0}, '{73, 1'b1, 1'b1, 1'b0}, '{80, 1'b1, 1'b1, 1'b0},
            '{81, 1'b1, 1'b0, 1'b1}, '{82, 1'b1, 1'b0, 1'b0}};
    cp_cyc = '{2608, 2609, 5216, 5217, 26080, 26081};
    cp_exp = '{3'b010, 3'b110, 3'b110, 3'b010, 3'b110, 3'b101};

    cyc = 0; t0 = 0; n_checks = 0; n_errors = 0; done_cnt = 0;
    model_on = 1'b0; m_fs = -1; m_byte = 8'h00; m_ovr = 1'b0;
    mon_act = 1'b0; mon_st = 0; mon_sh = 8'h00;
    rst = 1'b1; wr = 1'b0; bus = 8'h00;
    rst2 = 1'b1; wr2 = 1'b0; bus2 = 8'h00;
    repeat (3) step();

    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_overrun", {31'd0, ovr}, 32'd0);
    chk("reset_def_tx", {31'd0, tx2}, 32'd1);
    chk("reset_def_overrun", {31'd0, ovr2}, 32'd0);
    rst = 1'b0;
    model_on = 1'b1;

    // 0xA5 frame against the timing table
    start_test();
    pulse_write(8'hA5);
    for (int i = 0; i < 17; i++) begin
      wait_to(tbl[i].cyc);
      chk($sformatf("a5_tx_c%0d", tbl[i].cyc), {31'd0, tx}, {31'd0, tbl[i].tx});
      chk($sformatf("a5_busy_c%0d", tbl[i].cyc), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("a5_done_c%0d", tbl[i].cyc), {31'd0, done}, {31'd0, tbl[i].done});
    end
    wait_to(FT + 8);
    chk("a5_decoded_n", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) chk("a5_decoded", {24'd0, mon_q[0]}, 32'hA5);

    // back-to-back frames, second write on the done cycle
    start_test();
    dc0 = done_cnt;
    pulse_write(8'h70);
    wait_to(81);
    chk("b2b_done_c81", {31'd0, done}, 32'd1);
    pulse_write(8'h63);
    chk("b2b_start_c82", {31'd0, tx}, 32'd0);
    wait_to(82 + FT + 4);
    chk("b2b_done_count", done_cnt - dc0, 32'd2);
    chk("b2b_decoded_n", mon_q.size(), 32'd2);
    if (mon_q.size() == 2) begin
      chk("b2b_byte0", {24'd0, mon_q[0]}, 32'h70);
      chk("b2b_byte1", {24'd0, mon_q[1]}, 32'h63);
    end

    // overrun
    start_test();
    dc0 = done_cnt;
    pulse_write(8'h11);
    wait_to(20);
    chk("ovr_c20", {31'd0, ovr}, 32'd0);
    pulse_write(8'hFF);
    chk("ovr_c21", {31'd0, ovr}, 32'd1);
    step();
    chk("ovr_c22", {31'd0, ovr}, 32'd0);
    wait_to(FT + 20);
    chk("ovr_done_count", done_cnt - dc0, 32'd1);
    chk("ovr_decoded_n", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) chk("ovr_byte", {24'd0, mon_q[0]}, 32'h11);

    // reset mid-frame, then a clean frame
    start_test();
    dc0 = done_cnt;
    pulse_write(8'h00);
    wait_to(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_tx_c31", {31'd0, tx}, 32'd1);
    chk("rst_busy_c31", {31'd0, busy}, 32'd0);
    wait_to(40);
    chk("rst_no_done", done_cnt - dc0, 32'd0);
    pulse_write(8'h55);
    wait_to(120);
    chk("rst_done_c120", {31'd0, done}, 32'd0);
    step();
    chk("rst_done_c121", {31'd0, done}, 32'd1);
    wait_to(130);
    chk("rst_decoded_n", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) chk("rst_byte", {24'd0, mon_q[0]}, 32'h55);

    // tx_bus changes after accept have no effect
    start_test();
    pulse_write(8'h3C);
    bus = 8'hC3;
    wait_to(FT + 8);
    chk("stable_decoded_n", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) chk("stable_byte", {24'd0, mon_q[0]}, 32'h3C);

    // randomized writes and resets against the model
    start_test();
    for (int i = 0; i < 2500; i++) begin
      wr  = ($urandom_range(0, 11) == 0);
      bus = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    wr = 1'b0;
    rst = 1'b0;
    repeat (FT + 4) step();

    // default timing instance, 0x01
    rst2 = 1'b0;
    step();
    t0 = cyc;
    wr2 = 1'b1;
    bus2 = 8'h01;
    step();
    wr2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_to(cp_cyc[i]);
      chk($sformatf("def_tx_c%0d", cp_cyc[i]), {31'd0, tx2}, {31'd0, cp_exp[i][2]});
      chk($sformatf("def_busy_c%0d", cp_cyc[i]), {31'd0, busy2}, {31'd0, cp_exp[i][1]});
      chk($sformatf("def_done_c%0d", cp_cyc[i]), {31'd0, done2}, {31'd0, cp_exp[i][0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream stage of the debug unit's transmit path.
- Accepts one byte per tx_write strobe and serializes it onto the UART TX line as 8N1 (LSB first).
- Pulses tx_done when the stop bit completes, which advances the debug unit's SEND/SENDING byte-dump loop to the next dp_bus byte.
- Contains its own baud tick generation. There is no FIFO: one byte is in flight at a time.

Parameters:
- BAUD_DIV, 163, clocks per oversample tick (50 MHz / (19200*16)).
- OVERSAMPLE, 16, ticks per bit period.
- DBIT, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  in  1  system clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- tx_write  in  1  one-cycle strobe; tx_bus is valid on this cycle.
- tx_bus  in  8  byte to send.
- tx  out  1  serial line; idles high.
- tx_done  out  1  one-cycle pulse when a frame completes.
- tx_busy  out  1  high from the accept cycle through the last stop-bit clock.
- tx_overrun  out  1  one-cycle pulse when tx_write arrives while busy.

Behaviour:
- Reset values: tx=1, tx_done=0, tx_busy=0, tx_overrun=0, state=IDLE, all counters=0, shift register=0.
- Bit period T = BAUD_DIV*OVERSAMPLE clocks.
- Baud generator:
  - Counter runs 0..BAUD_DIV-1; tick=1 when count==BAUD_DIV-1.
  - Counter is cleared on byte accept, so frame timing is deterministic relative to the write.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_write, latch tx_bus into the shift register, clear the baud and tick counters, and go to START. tx_busy goes high the next cycle.
  - START: tx=0 for T clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for T clocks, then shift right and increment the bit index. After bit DBIT-1, go to STOP.
  - STOP: tx=1 for STOP_BITS*T clocks, then go to IDLE with tx_done=1 for exactly one cycle (the first IDLE cycle).
- Latency, with the write sampled at edge 0:
  - tx falls at cycle 1.
  - Data bit k starts at cycle 1+(k+1)*T.
  - tx_done is high at cycle 1+(1+DBIT+STOP_BITS)*T, i.e. 1+10T for 8N1.
- Byte is latched on accept; tx_bus may change afterward without effect.
- Write in the same cycle tx_done is high: accepted (state is IDLE), so back-to-back frames are possible with no gap beyond that one cycle.
- Write while busy (states START/DATA/STOP): the byte is dropped, tx_overrun pulses one cycle, and the current frame is unaffected.
- Write while reset is high: ignored.
- Reset mid-frame: at the next edge tx=1 and state=IDLE. The frame is truncated with no tx_done and no overrun.
- All outputs are registered: no combinational path from input to output.
- Width rules:
  - Bit index width = clog2(DBIT).
  - Tick counter width = clog2(OVERSAMPLE*STOP_BITS).
  - Baud counter width = clog2(BAUD_DIV).
  - Counters never wrap silently; each is reset at its state entry.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (one-hot, 4 bits, matching the team's one-hot parameter style).
  - Default BAUD_DIV and OVERSAMPLE constants, shared with the future uart_rx.
  - Frame constants DBIT and STOP_BITS.
- Sub-module baud_tick_gen (parameter BAUD_DIV; ports clk, reset, clear, tick). It is reused by the receiver.

Test Plan:
- BAUD_DIV=2, OVERSAMPLE=4 (T=8); write 0xA5 at cycle 0:
  - tx is low over cycles 1-8.
  - Data bits 1,0,1,0,0,1,0,1 each last 8 cycles starting at cycle 9.
  - tx is high from cycle 73.
  - tx_done is high only at cycle 81; tx_busy is high over cycles 1-80.
- Back-to-back: write 0x70 at cycle 0 and 0x63 at cycle 81 (the tx_done cycle):
  - Second start bit begins at cycle 82.
  - Both bytes decode correctly with a line-monitor model; exactly two tx_done pulses.
- Overrun: write 0x11 at cycle 0, then 0xFF at cycle 20:
  - tx_overrun pulses at cycle 21.
  - Serialized byte is 0x11; one tx_done only.
- Reset mid-frame: write 0x00, assert reset at cycle 30 for 1 cycle:
  - tx=1 from cycle 31; no tx_done.
  - A new write of 0x55 at cycle 40 produces a clean frame with tx_done at cycle 121.
- tx_bus stability: write 0x3C, then drive tx_bus=0xC3 from cycle 1 onward → line carries 0x3C.
- Default parameters (T=2608), 0x01 → tx_done at cycle 1+26080; bit 0 high over cycles 2609-5216.
